ccu_ctrl_mu_scheduler: RTL

CCU_CTRL_MU_SCHEDULER -- requirements
Module: ccu_ctrl_mu_scheduler

---
 rtl/ccu_ctrl_pkg.sv | 28 ++
 rtl/ccu_ctrl_rr_pick.sv | 37 +++
 rtl/ccu_ctrl_mu_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ccu_ctrl_pkg.sv
// Shared types for the CCU control path.
//   mu_op_e           : operations the memory unit can be asked to perform
//   mu_sched_state_e  : state of the memory-unit scheduler
//   is_write_back_op  : true for ops that push data through the CD FIFO
package ccu_ctrl_pkg;

    typedef enum logic [2:0] {
        SEND_AXI_REQ_R            = 3'd0,
        SEND_AXI_REQ_W            = 3'd1,
        SEND_AXI_REQ_WRITE_BACK_R = 3'd2,
        SEND_AXI_REQ_WRITE_BACK_W = 3'd3,
        READ_SNP_DATA             = 3'd4,
        SEND_INVALID_ACK_R        = 3'd5,
        SEND_INVALID_ACK_W        = 3'd6
    } mu_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_DONE = 2'd2
    } mu_sched_state_e;

    // Write-backs need a free CD FIFO, so they are held off while it is busy.
    function automatic logic is_write_back_op(input mu_op_e op);
        return (op == SEND_AXI_REQ_WRITE_BACK_R) || (op == SEND_AXI_REQ_WRITE_BACK_W);
    endfunction

endpackage

// File: rtl/ccu_ctrl_rr_pick.sv
// Combinational round-robin picker.
//   eligible_i : one bit per requester that may be granted this cycle
//   ptr_i      : index with highest priority this cycle
//   idx_o      : first eligible index at or after ptr_i, wrapping to 0
//   valid_o    : at least one requester is eligible
module ccu_ctrl_rr_pick #(
    parameter int unsigned  NoReq   = 2,
    localparam int unsigned IdxBits = (NoReq > 1) ? $clog2(NoReq) : 1
) (
    input  logic [NoReq-1:0]   eligible_i,
    input  logic [IdxBits-1:0] ptr_i,
    output logic [IdxBits-1:0] idx_o,
    output logic               valid_o
);

    // Two passes avoid modulo arithmetic: the upper slice [ptr..NoReq-1] is
    // searched first, the lower slice [0..ptr-1] only when the upper is empty.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NoReq; i++) begin
            if (!valid_o && eligible_i[i] && (i >= 32'(ptr_i))) begin
                valid_o = 1'b1;
                idx_o   = IdxBits'(i);
            end
        end
        for (int unsigned i = 0; i < NoReq; i++) begin
            if (!valid_o && eligible_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IdxBits'(i);
            end
        end
    end

endmodule

// File: rtl/ccu_ctrl_mu_scheduler.sv
// Arbitrates several decision-path requesters onto a single memory unit.
// One operation is in flight at a time: it is captured in IDLE, offered to
// the memory unit in OFFER and tracked until completion in WAIT_DONE.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_*_i / req_ready_o   : per-requester request and one-cycle capture strobe
//   mu_valid_o / mu_ready_i : offer handshake; mu_ready_i also signals "unit idle"
//   mu_*_o                  : registered payload of the captured operation
//   cd_busy_i               : CD FIFO busy, blocks write-back ops
//   grant_idx_o             : requester that owns the current/last operation
//   busy_o, timeout_o       : operation in flight; sticky overlong-operation flag
module ccu_ctrl_mu_scheduler
    import ccu_ctrl_pkg::*;
#(
    parameter int unsigned  NoReq         = 2,
    parameter int unsigned  NoMstPorts    = 4,
    parameter int unsigned  TimeoutCycles = 1024,
    parameter type          mst_req_t     = logic,
    localparam int unsigned MstIdxBits    = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned ReqIdxBits    = (NoReq > 1) ? $clog2(NoReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NoReq-1:0]      req_valid_i,
    output logic [NoReq-1:0]      req_ready_o,
    input  mu_op_e                req_op_i              [NoReq],
    input  mst_req_t              req_holder_i          [NoReq],
    input  logic [MstIdxBits-1:0] req_first_responder_i [NoReq],
    input  logic [NoMstPorts-1:0] req_data_available_i  [NoReq],
    output logic                  mu_valid_o,
    input  logic                  mu_ready_i,
    output mu_op_e                mu_op_o,
    output mst_req_t              mu_holder_o,
    output logic [MstIdxBits-1:0] mu_first_responder_o,
    output logic [NoMstPorts-1:0] mu_data_available_o,
    input  logic                  cd_busy_i,
    output logic [ReqIdxBits-1:0] grant_idx_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int unsigned CntBits = $clog2(TimeoutCycles + 1);

    mu_sched_state_e       state_q, state_d;
    logic [NoReq-1:0]      eligible;
    logic [ReqIdxBits-1:0] pick_idx, rr_ptr_q, grant_idx_q;
    logic                  pick_valid, capture;
    logic [CntBits-1:0]    cnt_q;
    logic                  timeout_q;

    mu_op_e                op_q;
    mst_req_t              holder_q;
    logic [MstIdxBits-1:0] responder_q;
    logic [NoMstPorts-1:0] data_avail_q;

    // A write-back is not dropped while the CD FIFO is busy; it simply is not
    // eligible, and the requester keeps it asserted until it wins later.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NoReq; i++) begin
            eligible[i] = req_valid_i[i] && !(cd_busy_i && is_write_back_op(req_op_i[i]));
        end
    end

    ccu_ctrl_rr_pick #(
        .NoReq (NoReq)
    ) i_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid && !rst_i) begin
                    capture = 1'b1;
                    state_d = OFFER;
                    for (int unsigned i = 0; i < NoReq; i++) begin
                        req_ready_o[i] = (pick_idx == ReqIdxBits'(i));
                    end
                end
            end
            OFFER:     if (mu_ready_i) state_d = WAIT_DONE;
            WAIT_DONE: if (mu_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            op_q         <= mu_op_e'('0);
            holder_q     <= '0;
            responder_q  <= '0;
            data_avail_q <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            state_q <= state_d;
            if (capture) begin
                op_q         <= req_op_i[pick_idx];
                holder_q     <= req_holder_i[pick_idx];
                responder_q  <= req_first_responder_i[pick_idx];
                data_avail_q <= req_data_available_i[pick_idx];
                grant_idx_q  <= pick_idx;
                rr_ptr_q     <= (pick_idx == ReqIdxBits'(NoReq - 1)) ? '0
                                                                     : pick_idx + ReqIdxBits'(1);
                cnt_q        <= '0;
            end else if (state_q != IDLE) begin
                if (cnt_q != CntBits'(TimeoutCycles)) begin
                    cnt_q <= cnt_q + CntBits'(1);
                end
                // Flag raised on the edge where the count reaches the limit.
                if (cnt_q == CntBits'(TimeoutCycles - 1)) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted so a reset in
    // OFFER never shows the abandoned operation again.
    assign mu_valid_o           = (state_q == OFFER) && !rst_i;
    assign busy_o               = (state_q != IDLE) && !rst_i;
    assign mu_op_o              = op_q;
    assign mu_holder_o          = holder_q;
    assign mu_first_responder_o = responder_q;
    assign mu_data_available_o  = data_avail_q;
    assign grant_idx_o          = grant_idx_q;
    assign timeout_o            = timeout_q;

endmodule
